// File: rtl/elevator_pkg.sv
// Shared elevator definitions: controller states, travel direction encoding
// and default geometry/timing constants reused by the buttons stage and the car controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DOOR_OPEN = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_t;

  localparam int DEFAULT_BUTTONS_WIDTH = 8;
  localparam int DEFAULT_FLOOR_TICKS   = 16;
  localparam int DEFAULT_DOOR_TICKS    = 32;

endpackage

// File: rtl/elevator_controller_request_scan.sv
// Combinational request scan: merges car and hall calls and reports whether
// any call exists at, above or below a given floor.
module request_scan
  import elevator_pkg::*;
#(
  parameter int BUTTONS_WIDTH = DEFAULT_BUTTONS_WIDTH,
  localparam int FW = $clog2(BUTTONS_WIDTH)
) (
  input  logic [BUTTONS_WIDTH-1:0] in_levels,
  input  logic [BUTTONS_WIDTH-2:0] up_levels,
  input  logic [BUTTONS_WIDTH-1:1] down_levels,
  input  logic [FW-1:0]            floor,
  output logic                     here,
  output logic                     above,
  output logic                     below
);

  logic [BUTTONS_WIDTH-1:0] any_call_s;

  assign any_call_s = in_levels | {1'b0, up_levels} | {down_levels, 1'b0};

  // classify every pending call relative to the probed floor
  always_comb begin
    here  = 1'b0;
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < BUTTONS_WIDTH; i++) begin
      here  = here  | (any_call_s[i] & (FW'(i) == floor));
      above = above | (any_call_s[i] & (FW'(i) >  floor));
      below = below | (any_call_s[i] & (FW'(i) <  floor));
    end
  end

endmodule

// File: rtl/elevator_controller.sv
// Collective (SCAN) car controller: moves the car floor by floor, opens the door,
// and returns clear strobes for every served call. All outputs are registered.
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int BUTTONS_WIDTH = DEFAULT_BUTTONS_WIDTH,
  parameter int FLOOR_TICKS   = DEFAULT_FLOOR_TICKS,
  parameter int DOOR_TICKS    = DEFAULT_DOOR_TICKS,
  localparam int FW = $clog2(BUTTONS_WIDTH)
) (
  input  logic                     clk,
  input  logic                     an_reset,
  input  logic [BUTTONS_WIDTH-1:0] active_in_levels,
  input  logic [BUTTONS_WIDTH-2:0] active_out_up_levels,
  input  logic [BUTTONS_WIDTH-1:1] active_out_down_levels,
  output logic [BUTTONS_WIDTH-1:0] inactivate_in_levels,
  output logic [BUTTONS_WIDTH-2:0] inactivate_out_up_levels,
  output logic [BUTTONS_WIDTH-1:1] inactivate_out_down_levels,
  output logic [FW-1:0]            current_floor,
  output logic [1:0]               direction,
  output logic                     motor_up,
  output logic                     motor_down,
  output logic                     door_open
);

  localparam int MAX_TICKS = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int TW        = $clog2(MAX_TICKS);
  localparam logic [TW-1:0] FLOOR_LAST = TW'(FLOOR_TICKS - 1);
  localparam logic [TW-1:0] DOOR_LAST  = TW'(DOOR_TICKS - 1);
  localparam logic [TW-1:0] TICK_ONE   = TW'(1);
  localparam logic [FW-1:0] TOP_FLOOR  = FW'(BUTTONS_WIDTH - 1);
  localparam logic [FW-1:0] FLOOR_ONE  = FW'(1);

  state_t        state_r, next_state_s;
  dir_t          dir_r, next_dir_s;
  logic [FW-1:0] floor_r, next_floor_s, arrive_floor_s;
  logic [TW-1:0] timer_r, next_timer_s;

  logic cur_here_s, cur_above_s, cur_below_s;
  logic arr_here_s, arr_above_s, arr_below_s;

  logic [BUTTONS_WIDTH-1:0] up_full_s, down_full_s;
  logic [BUTTONS_WIDTH-1:0] clr_in_s;
  logic [BUTTONS_WIDTH-2:0] clr_up_s;
  logic [BUTTONS_WIDTH-1:1] clr_down_s;

  assign up_full_s   = {1'b0, active_out_up_levels};
  assign down_full_s = {active_out_down_levels, 1'b0};

  request_scan #(.BUTTONS_WIDTH(BUTTONS_WIDTH)) u_scan_cur (
    .in_levels   (active_in_levels),
    .up_levels   (active_out_up_levels),
    .down_levels (active_out_down_levels),
    .floor       (floor_r),
    .here        (cur_here_s),
    .above       (cur_above_s),
    .below       (cur_below_s)
  );

  request_scan #(.BUTTONS_WIDTH(BUTTONS_WIDTH)) u_scan_arr (
    .in_levels   (active_in_levels),
    .up_levels   (active_out_up_levels),
    .down_levels (active_out_down_levels),
    .floor       (arrive_floor_s),
    .here        (arr_here_s),
    .above       (arr_above_s),
    .below       (arr_below_s)
  );

  // floor the car reaches next in its direction of travel (clamped to the shaft)
  always_comb begin
    arrive_floor_s = floor_r;
    case (state_r)
      MOVE_UP:   arrive_floor_s = (floor_r == TOP_FLOOR) ? floor_r : floor_r + FLOOR_ONE;
      MOVE_DOWN: arrive_floor_s = (floor_r == '0) ? floor_r : floor_r - FLOOR_ONE;
      default:   arrive_floor_s = floor_r;
    endcase
  end

  // SCAN scheduler: next state, floor, direction and timer
  always_comb begin
    next_state_s = state_r;
    next_floor_s = floor_r;
    next_dir_s   = dir_r;
    next_timer_s = timer_r;
    case (state_r)
      IDLE: begin
        next_timer_s = '0;
        if (cur_here_s) begin
          next_state_s = DOOR_OPEN;
          next_dir_s   = DIR_NONE;
        end else if (cur_above_s) begin
          next_state_s = MOVE_UP;
          next_dir_s   = DIR_UP;
        end else if (cur_below_s) begin
          next_state_s = MOVE_DOWN;
          next_dir_s   = DIR_DOWN;
        end else begin
          next_dir_s   = DIR_NONE;
        end
      end
      MOVE_UP: begin
        if (timer_r == FLOOR_LAST) begin
          next_floor_s = arrive_floor_s;
          next_timer_s = '0;
          // a call at the arrival floor that is not a car/up call can only be a down call
          if (arr_here_s & (active_in_levels[arrive_floor_s] | up_full_s[arrive_floor_s] | !arr_above_s)) begin
            next_state_s = DOOR_OPEN;
          end else if (arr_above_s) begin
            next_state_s = MOVE_UP;
          end else begin
            next_state_s = IDLE;
            next_dir_s   = DIR_NONE;
          end
        end else begin
          next_timer_s = timer_r + TICK_ONE;
        end
      end
      MOVE_DOWN: begin
        if (timer_r == FLOOR_LAST) begin
          next_floor_s = arrive_floor_s;
          next_timer_s = '0;
          if (arr_here_s & (active_in_levels[arrive_floor_s] | down_full_s[arrive_floor_s] | !arr_below_s)) begin
            next_state_s = DOOR_OPEN;
          end else if (arr_below_s) begin
            next_state_s = MOVE_DOWN;
          end else begin
            next_state_s = IDLE;
            next_dir_s   = DIR_NONE;
          end
        end else begin
          next_timer_s = timer_r + TICK_ONE;
        end
      end
      DOOR_OPEN: begin
        if (timer_r == DOOR_LAST) begin
          next_timer_s = '0;
          if (dir_r == DIR_UP && cur_above_s) begin
            next_state_s = MOVE_UP;
          end else if (dir_r == DIR_DOWN && cur_below_s) begin
            next_state_s = MOVE_DOWN;
          end else if (cur_above_s) begin
            next_state_s = MOVE_UP;
            next_dir_s   = DIR_UP;
          end else if (cur_below_s) begin
            next_state_s = MOVE_DOWN;
            next_dir_s   = DIR_DOWN;
          end else begin
            next_state_s = IDLE;
            next_dir_s   = DIR_NONE;
          end
        end else begin
          next_timer_s = timer_r + TICK_ONE;
        end
      end
      default: begin
        next_state_s = IDLE;
        next_dir_s   = DIR_NONE;
        next_timer_s = '0;
      end
    endcase
  end

  // clear strobes for the door cycle that follows; whenever the next state is
  // DOOR_OPEN the next floor equals the arrival floor, so its scan applies
  always_comb begin
    clr_in_s   = '0;
    clr_up_s   = '0;
    clr_down_s = '0;
    for (int i = 0; i < BUTTONS_WIDTH; i++) begin
      clr_in_s[i] = (next_state_s == DOOR_OPEN) && (arrive_floor_s == FW'(i));
    end
    for (int i = 0; i < BUTTONS_WIDTH - 1; i++) begin
      clr_up_s[i] = (next_state_s == DOOR_OPEN) && (arrive_floor_s == FW'(i)) &&
                    ((next_dir_s != DIR_DOWN) || !arr_below_s);
    end
    for (int i = 1; i < BUTTONS_WIDTH; i++) begin
      clr_down_s[i] = (next_state_s == DOOR_OPEN) && (arrive_floor_s == FW'(i)) &&
                      ((next_dir_s != DIR_UP) || !arr_above_s);
    end
  end

  // state, position and registered actuator/strobe outputs
  always_ff @(posedge clk) begin
    if (!an_reset) begin
      state_r                    <= IDLE;
      dir_r                      <= DIR_NONE;
      floor_r                    <= '0;
      timer_r                    <= '0;
      motor_up                   <= 1'b0;
      motor_down                 <= 1'b0;
      door_open                  <= 1'b0;
      inactivate_in_levels       <= '0;
      inactivate_out_up_levels   <= '0;
      inactivate_out_down_levels <= '0;
    end else begin
      state_r                    <= next_state_s;
      dir_r                      <= next_dir_s;
      floor_r                    <= next_floor_s;
      timer_r                    <= next_timer_s;
      motor_up                   <= (next_state_s == MOVE_UP);
      motor_down                 <= (next_state_s == MOVE_DOWN);
      door_open                  <= (next_state_s == DOOR_OPEN);
      inactivate_in_levels       <= clr_in_s;
      inactivate_out_up_levels   <= clr_up_s;
      inactivate_out_down_levels <= clr_down_s;
    end
  end

  assign current_floor = floor_r;
  assign direction     = dir_r;

endmodule

// File: tb/tb_elevator_controller.sv
// Scoreboard bench: expected output segments (value + duration) are queued with
// each stimulus; a negedge monitor pops one per output change and checks it.
module tb_elevator_controller;

  localparam int W  = 8;
  localparam int FT = 4;
  localparam int DT = 8;

  logic         clk = 1'b0;
  logic         an_reset;
  logic [W-1:0] act_in, clr_in;
  logic [W-2:0] act_up, clr_up;
  logic [W-1:1] act_dn, clr_dn;
  logic [2:0]   cur_floor;
  logic [1:0]   direction;
  logic         motor_up, motor_down, door_open;

  elevator_controller #(.BUTTONS_WIDTH(W), .FLOOR_TICKS(FT), .DOOR_TICKS(DT)) dut (
    .clk                        (clk),
    .an_reset                   (an_reset),
    .active_in_levels           (act_in),
    .active_out_up_levels       (act_up),
    .active_out_down_levels     (act_dn),
    .inactivate_in_levels       (clr_in),
    .inactivate_out_up_levels   (clr_up),
    .inactivate_out_down_levels (clr_dn),
    .current_floor              (cur_floor),
    .direction                  (direction),
    .motor_up                   (motor_up),
    .motor_down                 (motor_down),
    .door_open                  (door_open)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mu;
    logic       md;
    logic       dop;
    logic [1:0] dir;
    logic [2:0] fl;
    logic [7:0] ci;
    logic [6:0] cu;
    logic [6:0] cd;
  } snap_t;

  typedef struct {
    snap_t val;
    int    len;
  } exp_t;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    mon_en   = 1'b0;
  bit    have_prev = 1'b0;
  snap_t prev_s, cur_s;
  int    prev_len = 0;
  int    seg_len  = 0;
  int    seg_idx  = 0;
  exp_t  e;

  localparam logic [1:0] D_NONE = 2'b00;
  localparam logic [1:0] D_UP   = 2'b01;
  localparam logic [1:0] D_DOWN = 2'b10;

  task automatic push(input logic mu, input logic md, input logic dop, input logic [1:0] dir,
                      input int fl, input logic [7:0] ci, input logic [6:0] cu,
                      input logic [6:0] cd, input int len);
    exp_t x;
    x.val = '{mu: mu, md: md, dop: dop, dir: dir, fl: 3'(fl), ci: ci, cu: cu, cd: cd};
    x.len = len;
    exp_q.push_back(x);
  endtask

  task automatic push_idle(input int fl);
    push(1'b0, 1'b0, 1'b0, D_NONE, fl, 8'h00, 7'h00, 7'h00, 0);
  endtask

  task automatic push_moves(input bit up, input int from, input int n);
    for (int i = 0; i < n; i++) begin
      if (up) push(1'b1, 1'b0, 1'b0, D_UP,   from + i, 8'h00, 7'h00, 7'h00, FT);
      else    push(1'b0, 1'b1, 1'b0, D_DOWN, from - i, 8'h00, 7'h00, 7'h00, FT);
    end
  endtask

  // one clock: wait past the edge, then the buttons latch drops served calls
  task automatic tick();
    @(posedge clk);
    #1;
    act_in = act_in & ~clr_in;
    act_up = act_up & ~clr_up;
    act_dn = act_dn & ~clr_dn;
  endtask

  task automatic reset_car();
    push_idle(0);
    an_reset = 1'b0;
    tick();
    an_reset = 1'b1;
  endtask

  // monitor: every change of the output tuple opens a new expected segment
  always @(negedge clk) begin
    if (mon_en) begin
      cur_s = '{mu: motor_up, md: motor_down, dop: door_open, dir: direction, fl: cur_floor,
                ci: clr_in, cu: clr_up, cd: clr_dn};
      if (!have_prev || cur_s != prev_s) begin
        if (have_prev && prev_len != 0) begin
          n_checks++;
          if (seg_len != prev_len) begin
            n_fail++;
            $display("FAIL seg_len[%0d] actual=%0d expected=%0d", seg_idx - 1, seg_len, prev_len);
          end
        end
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_change[%0d] actual=%h expected=none", seg_idx, cur_s);
          prev_len = 0;
        end else begin
          e = exp_q.pop_front();
          n_checks++;
          if (cur_s !== e.val) begin
            n_fail++;
            $display("FAIL seg_value[%0d] actual=%h expected=%h", seg_idx, cur_s, e.val);
          end
          prev_len = e.len;
        end
        seg_idx++;
        seg_len = 1;
      end else begin
        seg_len++;
      end
      prev_s    = cur_s;
      have_prev = 1'b1;
    end
  end

  initial begin
    an_reset = 1'b0;
    act_in = W'($urandom);
    act_up = (W-1)'($urandom);
    act_dn = (W-1)'($urandom);
    @(posedge clk);
    #1;
    act_in = W'($urandom);
    act_up = (W-1)'($urandom);
    act_dn = (W-1)'($urandom);
    @(posedge clk);
    #1;
    an_reset = 1'b1;
    act_in = '0;
    act_up = '0;
    act_dn = '0;
    push_idle(0);
    mon_en = 1'b1;
    repeat (2) tick();

    // single car call to floor 3
    push_moves(1'b1, 0, 3);
    push(1'b0, 1'b0, 1'b1, D_UP, 3, 8'h08, 7'h08, 7'h04, DT);
    push_idle(3);
    act_in[3] = 1'b1;
    repeat (25) tick();

    // pass-by: car call 5 with hall-down 2, served on the way back
    reset_car();
    push_moves(1'b1, 0, 5);
    push(1'b0, 1'b0, 1'b1, D_UP, 5, 8'h20, 7'h20, 7'h10, DT);
    push_moves(1'b0, 5, 3);
    push(1'b0, 1'b0, 1'b1, D_DOWN, 2, 8'h04, 7'h04, 7'h02, DT);
    push_idle(2);
    act_in[5] = 1'b1;
    act_dn[2] = 1'b1;
    repeat (52) tick();

    // top floor hall-down call
    reset_car();
    push_moves(1'b1, 0, 7);
    push(1'b0, 1'b0, 1'b1, D_UP, 7, 8'h80, 7'h00, 7'h40, DT);
    push_idle(7);
    act_dn[7] = 1'b1;
    repeat (42) tick();

    // call at the current floor opens the door without moving
    reset_car();
    push(1'b0, 1'b0, 1'b1, D_NONE, 0, 8'h01, 7'h01, 7'h00, DT);
    push_idle(0);
    act_up[0] = 1'b1;
    repeat (12) tick();

    // reset while travelling between floors 2 and 3
    push(1'b1, 1'b0, 1'b0, D_UP, 0, 8'h00, 7'h00, 7'h00, FT);
    push(1'b1, 1'b0, 1'b0, D_UP, 1, 8'h00, 7'h00, 7'h00, FT);
    push(1'b1, 1'b0, 1'b0, D_UP, 2, 8'h00, 7'h00, 7'h00, 2);
    push_idle(0);
    act_in[5] = 1'b1;
    repeat (10) tick();
    an_reset = 1'b0;
    act_in = '0;
    tick();
    an_reset = 1'b1;
    repeat (4) tick();

    mon_en = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL pending_segments actual=%0d expected=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
